imm_operand_stage: RTL
======================

# imm_operand_stage

Execute-side consumer of the 33-bit immediate-extender output. It turns each toggle of the extender's bit 32 into a one-shot "new operand" event and selects ALU operand B (extended immediate or rt register value). It also buffers the result in a 2-entry queue with a valid/ready handshake toward the ALU, and counts events lost to back-pressure. It sits between the immediate extender and the ALU input.

## Interface
Parameters:
- DATA_W, 32, operand width; ext_in is DATA_W+1 bits.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous and active-low.
- ext_in  in  DATA_W+1  extender output: [DATA_W-1:0] extended value, [DATA_W] toggle bit (each toggle marks a new value).
- rt_data  in  DATA_W  register-file rt value, valid alongside ext_in.
- alu_src  in  1  1 = operand B is the immediate; 0 = operand B is rt_data.
- op_b  out  DATA_W  selected operand at the queue head.
- op_is_imm  out  1  alu_src captured with the head entry.
- op_valid  out  1  queue head valid.
- op_ready  in  1  ALU accepts the head this cycle.
- clr_stat  in  1  one-cycle pulse that clears overflow and drop_cnt.
- overflow  out  1  sticky; set when an event was dropped.
- drop_cnt  out  CNT_W  number of dropped events, saturating.

## Operation
- Capture register s1: every clock, s1 <= {ext_in, rt_data, alu_src}; tog_d <= s1 toggle bit.
- Event: evt = s1.tog XOR tog_d, evaluated in the cycle after capture.
- Entry data: value = s1.alu_src ? s1.ext[DATA_W-1:0] : s1.rt_data. op_is_imm = s1.alu_src.
- Queue: 2 entries, first in first out.
  - push = evt.
  - pop = op_valid & op_ready.
  - Full with push and pop in the same cycle: both occur, so occupancy stays 2 and ordering is preserved.
  - Full with push and no pop: the event is dropped, overflow <= 1, and drop_cnt increments, saturating at 2^CNT_W-1.
  - Empty with push and no pop: the entry is written and op_valid rises.
  - Empty: a pop is impossible because op_valid is 0.
- clr_stat: clears overflow and drop_cnt. If a drop occurs in the same cycle, the result is overflow=1 and drop_cnt=1 (the clear applies first, then the drop).
- op_b holds its last value when the queue is empty. op_b and op_is_imm are don't-care while op_valid=0, but must not be X after reset.

## Timing
- Reset, when rst_n=0 at a clock edge:
  - Queue empties; op_valid=0, op_b=0, op_is_imm=0, overflow=0, drop_cnt=0.
  - s1 <= inputs and tog_d <= ext_in[DATA_W], so no spurious event is generated on the first post-reset cycle.
- Latency: ext_in toggle sampled at edge k gives evt during cycle k..k+1, which gives the entry written and op_valid=1 after edge k+1 (2 clocks), provided the queue is not full.
- Input rule: the toggle and its data must be held for at least 1 full clock. Two toggles inside one clock period cancel and produce no event; this is legal and is not an error.
- Back-to-back toggles on consecutive cycles produce consecutive pushes.
- op_valid and op_b are stable until a pop, with no combinational path from op_ready to op_valid.
- Reset asserted mid-operation discards queued entries immediately at that edge.

## Structure
- Shared package cpu_pkg holds WORD_W=32, EXT_W=WORD_W+1, EXT_TOG_BIT=WORD_W and the drop-counter width constant. The extender and this stage both import it.
- One sub-module, operand_fifo2: a generic 2-entry queue providing push/pop/full/empty/head, with synchronous active-low reset.
- The top level contains the capture register, toggle detector, mux, and statistics logic.

## Test plan
- Reset with ext_in[32]=1, then hold ext_in constant for 10 cycles → op_valid stays 0 and drop_cnt=0.
- Toggle bit 32 with ext_in value 0xFFFF8000, alu_src=1, op_ready=1 → op_valid=1 exactly 2 clocks after the sampling edge, op_b=0xFFFF8000, op_is_imm=1, single-cycle valid.
- alu_src=0, rt_data=0x12345678, ext value 0x0000ABCD, toggle → op_b=0x12345678, op_is_imm=0.
- op_ready=0, then 3 toggles on consecutive cycles (values 1, 2, 3) → queue holds 1, 2; overflow=1, drop_cnt=1; release op_ready → outputs 1 then 2, then op_valid=0.
- Queue full with a toggle and op_ready=1 in the same cycle → no drop; order preserved; occupancy stays 2.
- 300 drops → drop_cnt=255; clr_stat pulsed together with a drop → overflow=1, drop_cnt=1; rst_n low mid-stream → op_valid=0 on the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants for the immediate extender and its consumers.
// No logic; constants only.
// Not applicable (no handshake).
package cpu_pkg;
    localparam int WORD_W      = 32;
    localparam int EXT_W       = WORD_W + 1;
    localparam int EXT_TOG_BIT = WORD_W;
    localparam int DROP_CNT_W  = 8;
endpackage

// File: rtl/operand_fifo2.sv
// Generic 2-entry FIFO; entry 0 is always the head, so the head holds its last value when empty.
// Latency: push visible at head one clock later when empty.
// Backpressure: a push while full without a pop in the same cycle is ignored.
module operand_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] r_ent0;
    logic [WIDTH-1:0] r_ent1;
    logic [1:0]       r_cnt;
    logic             w_do_pop;
    logic             w_do_push;

    // Qualify push/pop against occupancy; a full queue accepts a push only alongside a pop.
    always_comb begin
        w_do_pop  = 1'b0;
        w_do_push = 1'b0;
        w_do_pop  = pop && (r_cnt != 2'd0);
        w_do_push = push && ((r_cnt != 2'd2) || w_do_pop);
    end

    // Shift-style storage: entry 1 moves into entry 0 on a pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_do_push) begin
                        r_ent0 <= push_dat;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_do_push && w_do_pop) begin
                        r_ent0 <= push_dat;
                    end else if (w_do_push) begin
                        r_ent1 <= push_dat;
                        r_cnt  <= 2'd2;
                    end else if (w_do_pop) begin
                        r_cnt  <= 2'd0;
                    end
                end
                default: begin
                    if (w_do_pop) begin
                        r_ent0 <= r_ent1;
                        if (w_do_push) begin
                            r_ent1 <= push_dat;
                        end else begin
                            r_cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign head_dat = r_ent0;
    assign full     = (r_cnt == 2'd2);
    assign empty    = (r_cnt == 2'd0);
endmodule

// File: rtl/imm_operand_stage.sv
// Turns extender toggle edges into operand events, selects ALU operand B, queues it for the ALU.
// Latency: 2 clocks from the edge sampling a toggle to op_valid.
// Backpressure: 2-entry queue; events arriving while full with no pop are dropped and counted.
module imm_operand_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int CNT_W  = DROP_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W:0]   ext_in,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              alu_src,
    output logic [DATA_W-1:0] op_b,
    output logic              op_is_imm,
    output logic              op_valid,
    input  logic              op_ready,
    input  logic              clr_stat,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt
);
    logic [DATA_W:0]   r_s1_ext;
    logic [DATA_W-1:0] r_s1_rt;
    logic              r_s1_src;
    logic              r_tog_d;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_evt;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic [DATA_W:0]   w_entry;
    logic [DATA_W:0]   w_head;

    // Capture stage; during reset the delayed toggle is seeded from the live input so no event follows reset.
    always_ff @(posedge clk) begin
        r_s1_ext <= ext_in;
        r_s1_rt  <= rt_data;
        r_s1_src <= alu_src;
        if (!rst_n) begin
            r_tog_d <= ext_in[DATA_W];
        end else begin
            r_tog_d <= r_s1_ext[DATA_W];
        end
    end

    assign w_evt   = r_s1_ext[DATA_W] ^ r_tog_d;
    assign w_entry = {(r_s1_src ? r_s1_ext[DATA_W-1:0] : r_s1_rt), r_s1_src};
    assign w_pop   = op_valid & op_ready;
    assign w_drop  = w_evt & w_full & ~w_pop;

    operand_fifo2 #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_evt),
        .push_dat (w_entry),
        .pop      (w_pop),
        .head_dat (w_head),
        .full     (w_full),
        .empty    (w_empty)
    );

    // Drop statistics; a clear in the same cycle as a drop leaves exactly that one drop recorded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clr_stat) begin
            r_overflow <= w_drop;
            r_drop_cnt <= w_drop ? CNT_W'(1) : '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != {CNT_W{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign op_b      = w_head[DATA_W:1];
    assign op_is_imm = w_head[0];
    assign op_valid  = ~w_empty;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;
endmodule
